// File: rtl/comm_host.sv
// Host-side initiator for the pin-mux command protocol: serializes a command byte plus
// little-endian payload into uart_tx and assembles the little-endian response from uart_rx.
module comm_host #(
  parameter logic [7:0]  CMD_READ_PIN_MAP      = 8'h00,
  parameter logic [7:0]  CMD_WRITE_PIN_MAP     = 8'h01,
  parameter logic [7:0]  CMD_READ_ENABLE_MASK  = 8'h02,
  parameter logic [7:0]  CMD_WRITE_ENABLE_MASK = 8'h03,
  parameter int unsigned TIMEOUT_CYCLES        = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_payload,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        rsp_mismatch,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_data_ready,
  input  logic        tx_done,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data
);

  localparam logic [23:0] TIMEOUT_LIMIT = 24'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_RSP,
    ST_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] payload_q, payload_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [2:0]  tx_cnt_q, tx_cnt_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [23:0] to_cnt_q, to_cnt_d;
  logic        rsp_timeout_q, rsp_timeout_d;
  logic        rsp_mismatch_q, rsp_mismatch_d;
  logic        tx_done_prev_q, rx_ready_prev_q;

  logic       tx_evt, rx_evt, rx_accept;
  logic       finish, timeout_hit;
  logic [2:0] n_pay, n_rsp;
  logic [7:0] cmd_byte;

  assign tx_evt = tx_done & ~tx_done_prev_q;
  assign rx_evt = rx_ready & ~rx_ready_prev_q;

  // Response bytes are collected while sending too; DONE is excluded so the result stays frozen.
  assign rx_accept = rx_evt && (state_q inside {ST_SEND, ST_WAIT_TX, ST_WAIT_RSP})
                     && (rx_cnt_q < n_rsp);

  always_comb begin
    n_pay = 3'd0;
    n_rsp = 3'd4;
    case (op_q)
      2'd1:    begin n_pay = 3'd4; n_rsp = 3'd4; end
      2'd2:    begin n_pay = 3'd0; n_rsp = 3'd2; end
      2'd3:    begin n_pay = 3'd2; n_rsp = 3'd2; end
      default: begin n_pay = 3'd0; n_rsp = 3'd4; end
    endcase
  end

  always_comb begin
    case (req_op)
      2'd1:    cmd_byte = CMD_WRITE_PIN_MAP;
      2'd2:    cmd_byte = CMD_READ_ENABLE_MASK;
      2'd3:    cmd_byte = CMD_WRITE_ENABLE_MASK;
      default: cmd_byte = CMD_READ_PIN_MAP;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d        = state_q;
    op_d           = op_q;
    payload_d      = payload_q;
    tx_data_d      = tx_data_q;
    tx_cnt_d       = tx_cnt_q;
    rx_cnt_d       = rx_cnt_q;
    rsp_data_d     = rsp_data_q;
    to_cnt_d       = to_cnt_q;
    rsp_timeout_d  = rsp_timeout_q;
    rsp_mismatch_d = rsp_mismatch_q;
    finish         = 1'b0;
    timeout_hit    = 1'b0;

    if (rx_accept) begin
      rsp_data_d[{rx_cnt_q[1:0], 3'b000} +: 8] = rx_data;
      rx_cnt_d = rx_cnt_q + 3'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d           = req_op;
          payload_d      = req_payload;
          tx_data_d      = cmd_byte;
          tx_cnt_d       = 3'd0;
          rx_cnt_d       = 3'd0;
          rsp_data_d     = 32'd0;
          to_cnt_d       = 24'd0;
          rsp_timeout_d  = 1'b0;
          rsp_mismatch_d = 1'b0;
          state_d        = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (tx_evt) begin
          if (tx_cnt_q == n_pay) begin
            to_cnt_d = 24'd0;
            if (rx_cnt_d == n_rsp) finish = 1'b1;
            else                   state_d = ST_WAIT_RSP;
          end else begin
            tx_data_d = payload_q[{tx_cnt_q[1:0], 3'b000} +: 8];
            tx_cnt_d  = tx_cnt_q + 3'd1;
            state_d   = ST_SEND;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (rx_accept) begin
          to_cnt_d = 24'd0;
          if (rx_cnt_d == n_rsp) finish = 1'b1;
        end else if (to_cnt_q + 24'd1 == TIMEOUT_LIMIT) begin
          finish      = 1'b1;
          timeout_hit = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 24'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (finish) begin
      state_d       = ST_DONE;
      rsp_timeout_d = timeout_hit;
      case (op_q)
        2'd1:    rsp_mismatch_d = !timeout_hit && (rsp_data_d != payload_q);
        2'd3:    rsp_mismatch_d = !timeout_hit && (rsp_data_d[15:0] != payload_q[15:0]);
        default: rsp_mismatch_d = 1'b0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      op_q            <= 2'd0;
      payload_q       <= 32'd0;
      tx_data_q       <= 8'd0;
      tx_cnt_q        <= 3'd0;
      rx_cnt_q        <= 3'd0;
      rsp_data_q      <= 32'd0;
      to_cnt_q        <= 24'd0;
      rsp_timeout_q   <= 1'b0;
      rsp_mismatch_q  <= 1'b0;
      tx_done_prev_q  <= 1'b0;
      rx_ready_prev_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      payload_q       <= payload_d;
      tx_data_q       <= tx_data_d;
      tx_cnt_q        <= tx_cnt_d;
      rx_cnt_q        <= rx_cnt_d;
      rsp_data_q      <= rsp_data_d;
      to_cnt_q        <= to_cnt_d;
      rsp_timeout_q   <= rsp_timeout_d;
      rsp_mismatch_q  <= rsp_mismatch_d;
      tx_done_prev_q  <= tx_done;
      rx_ready_prev_q <= rx_ready;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign rsp_valid     = (state_q == ST_DONE);
  assign tx_data_ready = (state_q == ST_SEND);
  assign tx_data       = tx_data_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign rsp_mismatch  = rsp_mismatch_q;

endmodule

// File: tb/tb_comm_host.sv
// Self-checking bench for comm_host: a UART model checks the transmitted byte stream and a
// response scoreboard checks each rsp_valid pulse (data, flags, cycle) against pushed expectations.
module tb_comm_host;

  localparam int TIMEOUT = 50;
  localparam int TX_LAT  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_payload = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        rsp_mismatch;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_data_ready;
  logic        tx_done = 1'b0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'd0;

  comm_host #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_payload  (req_payload),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_timeout  (rsp_timeout),
    .rsp_mismatch (rsp_mismatch),
    .busy         (busy),
    .tx_data      (tx_data),
    .tx_data_ready(tx_data_ready),
    .tx_done      (tx_done),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       last;
  } tx_exp_t;

  typedef struct {
    logic [31:0] data;
    logic        to;
    logic        mm;
    int          at;
  } rsp_exp_t;

  tx_exp_t  tx_q[$];
  rsp_exp_t rsp_q[$];

  int tx_seen = 0, tx_done_cnt = 0, tx_pushed = 0;
  int accept_cnt = 0, rsp_cnt = 0, rdy_bad = 0;
  int last_accept_cyc = 0, last_rsp_cyc = 0;
  bit tx_abort = 1'b0;

  function automatic logic [7:0] cmd_of(input logic [1:0] op);
    case (op)
      2'd0:    return 8'h00;
      2'd1:    return 8'h01;
      2'd2:    return 8'h02;
      default: return 8'h03;
    endcase
  endfunction

  function automatic int n_pay_of(input logic [1:0] op);
    case (op)
      2'd1:    return 4;
      2'd3:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int get_cnt(input int which);
    case (which)
      0:       return accept_cnt;
      1:       return tx_done_cnt;
      2:       return rsp_cnt;
      default: return tx_seen;
    endcase
  endfunction

  // UART transmitter model: checks each started byte, its hold, and the next-pulse latency.
  initial begin : tx_model
    tx_exp_t e;
    bit      ok;
    bit      gap_pending;
    gap_pending = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (gap_pending) begin
        check("tx_gap", 32'(tx_data_ready), 32'd1);
        gap_pending = 1'b0;
      end
      if (tx_data_ready) begin
        tx_seen++;
        if (tx_q.size() == 0) begin
          check("tx_extra", 32'(tx_data), 32'hffff_ffff);
        end else begin
          e = tx_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(e.b));
          ok = 1'b1;
          for (int i = 0; i < TX_LAT; i++) begin
            @(negedge clk);
            if (!tx_abort && (tx_data !== e.b || tx_data_ready !== 1'b0)) ok = 1'b0;
          end
          if (!tx_abort) begin
            check("tx_hold", 32'(ok), 32'd1);
            tx_done     = 1'b1;
            tx_done_cnt++;
            gap_pending = !e.last;
          end
        end
      end
    end
  end

  // Response scoreboard.
  initial begin : rsp_monitor
    rsp_exp_t e;
    bit       pulse_pending;
    pulse_pending = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (pulse_pending) begin
        check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        check("ready_after_rsp", 32'(req_ready), 32'd1);
        pulse_pending = 1'b0;
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_extra", 32'(rsp_valid), 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
          check("rsp_mismatch", 32'(rsp_mismatch), 32'(e.mm));
          check("rsp_cycle", 32'(cyc), 32'(e.at));
        end
        rsp_cnt++;
        last_rsp_cyc  = cyc;
        pulse_pending = 1'b1;
      end
    end
  end

  initial begin : accept_monitor
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && req_valid && req_ready) begin
        accept_cnt++;
        last_accept_cyc = cyc;
      end
      if (busy && req_ready) rdy_bad++;
    end
  end

  task automatic wait_counter(input int which, input int target, input int budget,
                              input string tag);
    int n = 0;
    while (get_cnt(which) < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(get_cnt(which) >= target), 32'd1);
  endtask

  task automatic push_tx(input logic [1:0] op, input logic [31:0] pay);
    int np;
    np = n_pay_of(op);
    tx_q.push_back('{b: cmd_of(op), last: (np == 0)});
    for (int i = 0; i < np; i++) tx_q.push_back('{b: pay[i*8 +: 8], last: (i == np - 1)});
    tx_pushed += 1 + np;
  endtask

  task automatic start_req(input logic [1:0] op, input logic [31:0] pay);
    int base;
    push_tx(op, pay);
    @(negedge clk);
    base        = accept_cnt;
    req_valid   = 1'b1;
    req_op      = op;
    req_payload = pay;
    wait_counter(0, base + 1, 20, "accept");
    req_valid = 1'b0;
  endtask

  task automatic finish_rsp(input int tx_target, input int n_rx, input logic [31:0] word,
                            input logic [31:0] exp_data, input logic exp_to,
                            input logic exp_mm, input bit check_hold);
    int base;
    base = rsp_cnt;
    wait_counter(1, tx_target, 200, "tx_all_done");
    for (int k = 0; k < n_rx; k++) begin
      @(negedge clk);
      // Last byte detected in cycle R: rsp_valid in R+1, or after TIMEOUT idle cycles on timeout.
      if (k == n_rx - 1)
        rsp_q.push_back('{data: exp_data, to: exp_to, mm: exp_mm,
                          at: cyc + (exp_to ? TIMEOUT + 1 : 1)});
      rx_data  = word[k*8 +: 8];
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
    wait_counter(2, base + 1, TIMEOUT + 20, "rsp_seen");
    if (check_hold) begin
      repeat (3) @(negedge clk);
      check("rsp_hold", rsp_data, exp_data);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base_seen, base_acc, tgt1, tgt2, first_rsp_cyc;

    repeat (2) @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_flags", {30'd0, rsp_timeout, rsp_mismatch}, 32'd0);
    check("reset_tx_data_ready", 32'(tx_data_ready), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read pin map.
    start_req(2'd0, 32'd0);
    finish_rsp(tx_pushed, 4, 32'h89abcdef, 32'h89abcdef, 1'b0, 1'b0, 1'b1);

    // Write enable mask, matching and mismatching echo.
    start_req(2'd3, 32'h0000abcd);
    finish_rsp(tx_pushed, 2, 32'h0000abcd, 32'h0000abcd, 1'b0, 1'b0, 1'b1);
    start_req(2'd3, 32'h0000abcd);
    finish_rsp(tx_pushed, 2, 32'h0000aacd, 32'h0000aacd, 1'b0, 1'b1, 1'b1);

    // Write pin map.
    start_req(2'd1, 32'haaff5500);
    finish_rsp(tx_pushed, 4, 32'haaff5500, 32'haaff5500, 1'b0, 1'b0, 1'b1);

    // Read enable mask, only one response byte arrives.
    start_req(2'd2, 32'd0);
    finish_rsp(tx_pushed, 1, 32'h0000005a, 32'h0000005a, 1'b1, 1'b0, 1'b1);

    // Reset during the second payload byte of a pin-map write.
    base_seen = tx_seen;
    start_req(2'd1, 32'h11223344);
    wait_counter(3, base_seen + 3, 100, "second_payload_started");
    @(negedge clk);
    tx_abort = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tx_q.delete();
    tx_pushed = tx_done_cnt;
    @(negedge clk);
    rx_data  = 8'h77;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (TX_LAT + 3) @(negedge clk);
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_rsp_data", rsp_data, 32'd0);
    tx_abort = 1'b0;
    start_req(2'd2, 32'd0);
    finish_rsp(tx_pushed, 2, 32'h00001234, 32'h00001234, 1'b0, 1'b0, 1'b1);

    // Back-to-back reads with req_valid held high.
    push_tx(2'd0, 32'd0);
    tgt1 = tx_pushed;
    push_tx(2'd0, 32'd0);
    tgt2 = tx_pushed;
    @(negedge clk);
    base_acc    = accept_cnt;
    req_valid   = 1'b1;
    req_op      = 2'd0;
    req_payload = 32'd0;
    finish_rsp(tgt1, 4, 32'h01020304, 32'h01020304, 1'b0, 1'b0, 1'b0);
    first_rsp_cyc = last_rsp_cyc;
    wait_counter(0, base_acc + 2, 10, "b2b_second_accept");
    check("b2b_accept_cycle", 32'(last_accept_cyc), 32'(first_rsp_cyc + 1));
    req_valid = 1'b0;
    finish_rsp(tgt2, 4, 32'hcafef00d, 32'hcafef00d, 1'b0, 1'b0, 1'b1);

    repeat (5) @(negedge clk);
    check("ready_low_while_busy", 32'(rdy_bad), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
